lock_code_programmer: RTL and testbench

Password-change front end for the two-stage locked box: the user authenticates with the current two 4-bit codes on the four toggle switches, then enters a new pair twice. On a successful re-entry the block commits the new pair to the Code1/Code2 registers, which the lock checker compares against. Raw push-buttons are debounced internally. Progress is shown on the 9-bit seven-segment output and the two LEDs.

---
 rtl/lock_code_programmer.sv | 203 ++++++++++++++++++++
 tb/tb_lock_code_programmer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lock_code_programmer.sv
// Password-change front end for the two-stage lock: authenticates the current
// Code1/Code2 pair, takes a new pair twice and commits it on a matching re-entry.

module lock_code_debounce #(
    parameter logic [19:0] CYCLES = 20'd500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    logic        sync1;
    logic        sync2;
    logic        level;
    logic [19:0] cnt;

    // Level follows the synchronized input only after CYCLES disagreeing cycles;
    // press pulses for one cycle on an accepted 1->0 change.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CYCLES - 20'd1) begin
                level <= sync2;
                cnt   <= '0;
                press <= ~sync2;
            end else begin
                cnt <= cnt + 20'd1;
            end
        end
    end

endmodule

module lock_code_programmer #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
    parameter logic [27:0] TIMEOUT_CYCLES  = 28'd150000000,
    parameter logic [25:0] HOLD_CYCLES     = 26'd50000000,
    parameter logic [3:0]  DEFAULT_CODE1   = 4'b1010,
    parameter logic [3:0]  DEFAULT_CODE2   = 4'b0101
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Key1,
    input  logic       Key2,
    input  logic       Key3,
    input  logic       Key4,
    input  logic       Button_Set,
    input  logic       Button_Confirm,
    output logic [3:0] Code1,
    output logic [3:0] Code2,
    output logic       Code_Update,
    output logic       Busy,
    output logic [1:0] LED,
    output logic [8:0] Seg_Led
);

    localparam int unsigned TIMER_W = 28;

    typedef enum logic [3:0] {
        IDLE, AUTH1, AUTH2, NEW1, NEW2, VERIF1, VERIF2, DONE, ERROR
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           key_s1, key_s2;
    logic                 set_ev, conf_ev;
    logic [3:0]           stage1_q, stage1_d, stage2_q, stage2_d;
    logic [3:0]           code1_d, code2_d;
    logic                 update_d, busy_d;
    logic [1:0]           led_d;
    logic [8:0]           seg_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 active, go, tmo, hold_done;

    lock_code_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_set (
        .clk(Clk), .rst_n(Rst_n), .raw(Button_Set), .press(set_ev)
    );

    lock_code_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_conf (
        .clk(Clk), .rst_n(Rst_n), .raw(Button_Confirm), .press(conf_ev)
    );

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            key_s1      <= '0;
            key_s2      <= '0;
            state_q     <= IDLE;
            stage1_q    <= '0;
            stage2_q    <= '0;
            timer_q     <= '0;
            Code1       <= DEFAULT_CODE1;
            Code2       <= DEFAULT_CODE2;
            Code_Update <= 1'b0;
            Busy        <= 1'b0;
            LED         <= 2'b11;
            Seg_Led     <= 9'h039;
        end else begin
            key_s1      <= {Key1, Key2, Key3, Key4};
            key_s2      <= key_s1;
            state_q     <= state_d;
            stage1_q    <= stage1_d;
            stage2_q    <= stage2_d;
            timer_q     <= timer_d;
            Code1       <= code1_d;
            Code2       <= code2_d;
            Code_Update <= update_d;
            Busy        <= busy_d;
            LED         <= led_d;
            Seg_Led     <= seg_d;
        end
    end

    // Next state, datapath updates, and output values decoded from the next state.
    always_comb begin
        state_d   = state_q;
        stage1_d  = stage1_q;
        stage2_d  = stage2_q;
        code1_d   = Code1;
        code2_d   = Code2;
        update_d  = 1'b0;
        busy_d    = 1'b1;
        led_d     = 2'b11;
        seg_d     = 9'h039;
        active    = (state_q == AUTH1) || (state_q == AUTH2) || (state_q == NEW1) ||
                    (state_q == NEW2) || (state_q == VERIF1) || (state_q == VERIF2);
        go        = conf_ev && !set_ev;
        tmo       = (timer_q == TIMEOUT_CYCLES - 28'd1);
        hold_done = (timer_q == TIMER_W'(HOLD_CYCLES) - 28'd1);

        case (state_q)
            IDLE:   if (set_ev) state_d = AUTH1;
            AUTH1:  if (go) state_d = (key_s2 == Code1) ? AUTH2 : ERROR;
            AUTH2:  if (go) state_d = (key_s2 == Code2) ? NEW1 : ERROR;
            NEW1: begin
                if (go) begin
                    stage1_d = key_s2;
                    state_d  = NEW2;
                end
            end
            NEW2: begin
                if (go) begin
                    stage2_d = key_s2;
                    state_d  = VERIF1;
                end
            end
            VERIF1: if (go) state_d = (key_s2 == stage1_q) ? VERIF2 : ERROR;
            VERIF2: begin
                if (go) begin
                    if (key_s2 == stage2_q) begin
                        code1_d  = stage1_q;
                        code2_d  = stage2_q;
                        update_d = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            DONE, ERROR: if (hold_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Cancel beats confirm; a pending confirm beats the timeout.
        if (active) begin
            if (set_ev) begin
                state_d = IDLE;
            end else if (!conf_ev && tmo) begin
                state_d = IDLE;
            end
        end

        if (state_d == IDLE) begin
            stage1_d = '0;
            stage2_d = '0;
        end

        timer_d = ((state_d != state_q) || (state_d == IDLE)) ? '0 : timer_q + 28'd1;

        case (state_d)
            IDLE:   begin seg_d = 9'h039; busy_d = 1'b0; end
            AUTH1:  seg_d = 9'h006;
            AUTH2:  begin seg_d = 9'h05b; led_d = 2'b01; end
            NEW1:   begin seg_d = 9'h04f; led_d = 2'b01; end
            NEW2:   begin seg_d = 9'h066; led_d = 2'b01; end
            VERIF1: begin seg_d = 9'h06d; led_d = 2'b00; end
            VERIF2: begin seg_d = 9'h07d; led_d = 2'b00; end
            DONE:   begin seg_d = 9'h03f; led_d = 2'b00; end
            ERROR:  seg_d = 9'h079;
            default: begin seg_d = 9'h039; busy_d = 1'b0; end
        endcase
    end

endmodule

// File: tb/tb_lock_code_programmer.sv
// Directed bench for lock_code_programmer with short debounce/timeout/hold values.

module tb_lock_code_programmer;

    logic       clk;
    logic       rst_n;
    logic       key1, key2, key3, key4;
    logic       btn_set, btn_conf;
    logic [3:0] code1, code2;
    logic       code_update, busy;
    logic [1:0] led;
    logic [8:0] seg;

    int vectors;
    int miscompares;
    int upd_cnt;

    lock_code_programmer #(
        .DEBOUNCE_CYCLES(20'd4),
        .TIMEOUT_CYCLES (28'd200),
        .HOLD_CYCLES    (26'd10),
        .DEFAULT_CODE1  (4'b1010),
        .DEFAULT_CODE2  (4'b0101)
    ) dut (
        .Clk(clk), .Rst_n(rst_n),
        .Key1(key1), .Key2(key2), .Key3(key3), .Key4(key4),
        .Button_Set(btn_set), .Button_Confirm(btn_conf),
        .Code1(code1), .Code2(code2), .Code_Update(code_update),
        .Busy(busy), .LED(led), .Seg_Led(seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (code_update) upd_cnt++;

    typedef struct {
        logic       rst;
        logic       is_set;
        logic [3:0] word;
        logic [8:0] seg;
        logic [1:0] led;
        logic       busy;
        logic [3:0] c1;
        logic [3:0] c2;
        logic       upd;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        btn_set  = 1'b1;
        btn_conf = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Press one or both buttons; returns once Seg_Led changes (bounded), buttons released.
    task automatic press(input logic use_set, input logic use_conf, input logic [3:0] w,
                         output logic ok);
        logic [8:0] old;
        {key1, key2, key3, key4} = w;
        repeat (10) @(negedge clk);
        old = seg;
        if (use_set)  btn_set  = 1'b0;
        if (use_conf) btn_conf = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (seg != old) begin
                ok = 1'b1;
                break;
            end
        end
        btn_set  = 1'b1;
        btn_conf = 1'b1;
    endtask

    task automatic step(input string name, input logic use_set, input logic [3:0] w,
                        input logic [8:0] exp_seg);
        logic ok;
        press(use_set, !use_set, w, ok);
        chk({name, " seg"}, 32'(seg), 32'(exp_seg));
    endtask

    task automatic measure(input logic [8:0] s, output int n);
        n = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (seg != s) break;
            n++;
        end
    endtask

    initial begin
        int   n;
        int   upd0;
        logic ok;

        vectors = 0; miscompares = 0; upd_cnt = 0;
        rst_n = 1'b0; btn_set = 1'b1; btn_conf = 1'b1;
        {key1, key2, key3, key4} = 4'b0000;

        //          rst   set   word   seg     led    busy  c1     c2     upd
        vecs[0]  = '{1'b1, 1'b1, 4'h0, 9'h006, 2'b11, 1'b1, 4'ha, 4'h5, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 4'ha, 9'h05b, 2'b01, 1'b1, 4'ha, 4'h5, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 4'h5, 9'h04f, 2'b01, 1'b1, 4'ha, 4'h5, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 4'h3, 9'h066, 2'b01, 1'b1, 4'ha, 4'h5, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 4'hc, 9'h06d, 2'b00, 1'b1, 4'ha, 4'h5, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 4'h3, 9'h07d, 2'b00, 1'b1, 4'ha, 4'h5, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 4'hc, 9'h03f, 2'b00, 1'b1, 4'h3, 4'hc, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 4'h0, 9'h006, 2'b11, 1'b1, 4'h3, 4'hc, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 4'ha, 9'h079, 2'b11, 1'b1, 4'h3, 4'hc, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 4'h0, 9'h006, 2'b11, 1'b1, 4'ha, 4'h5, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 4'hf, 9'h079, 2'b11, 1'b1, 4'ha, 4'h5, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 4'h0, 9'h006, 2'b11, 1'b1, 4'ha, 4'h5, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 4'ha, 9'h05b, 2'b01, 1'b1, 4'ha, 4'h5, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 4'h5, 9'h04f, 2'b01, 1'b1, 4'ha, 4'h5, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 4'h3, 9'h066, 2'b01, 1'b1, 4'ha, 4'h5, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 4'hc, 9'h06d, 2'b00, 1'b1, 4'ha, 4'h5, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 4'h7, 9'h079, 2'b11, 1'b1, 4'ha, 4'h5, 1'b0};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst seg",  32'(seg), 32'h039);
        chk("rst led",  32'(led), 32'h3);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst upd",  32'(code_update), 32'h0);
        chk("rst code1", 32'(code1), 32'ha);
        chk("rst code2", 32'(code2), 32'h5);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].rst) do_reset();
            press(vecs[i].is_set, !vecs[i].is_set, vecs[i].word, ok);
            chk($sformatf("v%0d event", i), 32'(ok), 32'h1);
            chk($sformatf("v%0d seg", i), 32'(seg), 32'(vecs[i].seg));
            chk($sformatf("v%0d led", i), 32'(led), 32'(vecs[i].led));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("v%0d code1", i), 32'(code1), 32'(vecs[i].c1));
            chk($sformatf("v%0d code2", i), 32'(code2), 32'(vecs[i].c2));
            chk($sformatf("v%0d upd", i), 32'(code_update), 32'(vecs[i].upd));
            if (vecs[i].seg == 9'h03f || vecs[i].seg == 9'h079) begin
                measure(vecs[i].seg, n);
                chk($sformatf("v%0d hold", i), 32'(n), 32'd10);
                chk($sformatf("v%0d idle seg", i), 32'(seg), 32'h039);
                chk($sformatf("v%0d idle led", i), 32'(led), 32'h3);
                chk($sformatf("v%0d idle busy", i), 32'(busy), 32'h0);
            end
        end
        chk("update pulses", 32'(upd_cnt), 32'd1);

        // Glitch and long hold on Confirm in AUTH1
        do_reset();
        step("glitch set", 1'b1, 4'ha, 9'h006);
        repeat (10) @(negedge clk);
        btn_conf = 1'b0;
        repeat (3) @(negedge clk);
        btn_conf = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch seg", 32'(seg), 32'h006);
        btn_conf = 1'b0;
        repeat (50) @(negedge clk);
        btn_conf = 1'b1;
        repeat (15) @(negedge clk);
        chk("hold50 seg", 32'(seg), 32'h05b);
        chk("hold50 led", 32'(led), 32'h1);

        // Simultaneous Set and Confirm in AUTH1 cancels
        do_reset();
        step("simul set", 1'b1, 4'ha, 9'h006);
        press(1'b1, 1'b1, 4'ha, ok);
        chk("simul seg", 32'(seg), 32'h039);
        chk("simul busy", 32'(busy), 32'h0);

        // Cancel in NEW2
        do_reset();
        upd0 = upd_cnt;
        step("cancel a", 1'b1, 4'h0, 9'h006);
        step("cancel b", 1'b0, 4'ha, 9'h05b);
        step("cancel c", 1'b0, 4'h5, 9'h04f);
        step("cancel d", 1'b0, 4'h3, 9'h066);
        step("cancel e", 1'b1, 4'hc, 9'h039);
        chk("cancel code1", 32'(code1), 32'ha);
        chk("cancel code2", 32'(code2), 32'h5);
        chk("cancel upd", 32'(upd_cnt - upd0), 32'd0);

        // Timeout in AUTH2
        do_reset();
        step("tmo a", 1'b1, 4'h0, 9'h006);
        step("tmo b", 1'b0, 4'ha, 9'h05b);
        measure(9'h05b, n);
        chk("tmo cycles", 32'(n), 32'd200);
        chk("tmo seg", 32'(seg), 32'h039);
        chk("tmo busy", 32'(busy), 32'h0);

        // Reset in VERIF2 after an earlier commit
        do_reset();
        step("rm 1", 1'b1, 4'h0, 9'h006);
        step("rm 2", 1'b0, 4'ha, 9'h05b);
        step("rm 3", 1'b0, 4'h5, 9'h04f);
        step("rm 4", 1'b0, 4'h3, 9'h066);
        step("rm 5", 1'b0, 4'hc, 9'h06d);
        step("rm 6", 1'b0, 4'h3, 9'h07d);
        step("rm 7", 1'b0, 4'hc, 9'h03f);
        measure(9'h03f, n);
        step("rm 8", 1'b1, 4'h0, 9'h006);
        step("rm 9", 1'b0, 4'h3, 9'h05b);
        step("rm 10", 1'b0, 4'hc, 9'h04f);
        step("rm 11", 1'b0, 4'h3, 9'h066);
        step("rm 12", 1'b0, 4'hc, 9'h06d);
        step("rm 13", 1'b0, 4'h3, 9'h07d);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rm code1", 32'(code1), 32'ha);
        chk("rm code2", 32'(code2), 32'h5);
        chk("rm seg", 32'(seg), 32'h039);
        chk("rm led", 32'(led), 32'h3);
        chk("rm busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
